// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for alu_mc: operands and mode in, result and flags out.
interface alu_mc_if #(
   parameter int N = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   mode;
   logic [N-1:0] in_a;
   logic [N-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out;
   logic [N-1:0] out_hi;
   logic         out_err;
   logic         flag_zero;
   logic         flag_carry;
   logic         flag_negative;
   logic         flag_overflow;

   modport master (
      output in_valid, mode, in_a, in_b, out_ready,
      input  in_ready, out_valid, out, out_hi, out_err,
             flag_zero, flag_carry, flag_negative, flag_overflow
   );

   modport slave (
      input  in_valid, mode, in_a, in_b, out_ready,
      output in_ready, out_valid, out, out_hi, out_err,
             flag_zero, flag_carry, flag_negative, flag_overflow
   );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus an N-cycle
// shift-add multiplier, with valid/ready handshakes on both sides.
module alu_mc #(
   parameter int N = 8
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_mc_if.slave  bus
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_ADC = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_SBC = 4'd3;
   localparam logic [3:0] OP_INC = 4'd4;
   localparam logic [3:0] OP_DEC = 4'd5;
   localparam logic [3:0] OP_AND = 4'd6;
   localparam logic [3:0] OP_OR  = 4'd7;
   localparam logic [3:0] OP_XOR = 4'd8;
   localparam logic [3:0] OP_SHL = 4'd9;
   localparam logic [3:0] OP_SHR = 4'd10;
   localparam logic [3:0] OP_ROL = 4'd11;
   localparam logic [3:0] OP_ROR = 4'd12;
   localparam logic [3:0] OP_MUL = 4'd13;
   localparam logic [3:0] OP_CMP = 4'd14;
   localparam logic [3:0] OP_ILL = 4'd15;

   localparam logic [N-1:0] LAST = N'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   mcand_q, mcand_d;
   logic [2*N-1:0] acc_q, acc_d;
   logic [N-1:0]   cnt_q, cnt_d;
   logic [N-1:0]   out_q, out_d;
   logic [N-1:0]   out_hi_q, out_hi_d;
   logic           err_q, err_d;
   logic           zero_q, zero_d;
   logic           carry_q, carry_d;
   logic           neg_q, neg_d;
   logic           ovf_q, ovf_d;

   logic [N-1:0]   opb;
   logic           cin;
   logic           sub;
   logic [N:0]     arith;
   logic [N-1:0]   sc_res;
   logic           sc_c;
   logic           sc_v;
   logic           sc_err;
   logic           sc_cmp;
   logic [N:0]     mul_sum;
   logic [2*N-1:0] mul_next;

   // Single-cycle datapath, evaluated straight from the bus inputs so the
   // result can be captured on the accept edge.
   always_comb begin
      opb = bus.in_b;
      cin = 1'b0;
      sub = 1'b0;
      case (bus.mode)
         OP_ADC:         cin = carry_q;
         OP_SUB, OP_CMP: sub = 1'b1;
         OP_SBC: begin
            sub = 1'b1;
            cin = carry_q;
         end
         OP_INC:         opb = N'(1);
         OP_DEC: begin
            opb = N'(1);
            sub = 1'b1;
         end
         default: ;
      endcase

      // Bit N of the subtraction is the borrow.
      if (sub)
         arith = {1'b0, bus.in_a} - {1'b0, opb} - {{N{1'b0}}, cin};
      else
         arith = {1'b0, bus.in_a} + {1'b0, opb} + {{N{1'b0}}, cin};

      sc_res = arith[N-1:0];
      sc_c   = arith[N];
      sc_v   = (sub ? (bus.in_a[N-1] != opb[N-1]) : (bus.in_a[N-1] == opb[N-1]))
               && (arith[N-1] != bus.in_a[N-1]);
      sc_err = 1'b0;
      sc_cmp = 1'b0;
      case (bus.mode)
         OP_AND: begin sc_res = bus.in_a & bus.in_b; sc_c = 1'b0; sc_v = 1'b0; end
         OP_OR:  begin sc_res = bus.in_a | bus.in_b; sc_c = 1'b0; sc_v = 1'b0; end
         OP_XOR: begin sc_res = bus.in_a ^ bus.in_b; sc_c = 1'b0; sc_v = 1'b0; end
         OP_SHL: begin sc_res = {bus.in_a[N-2:0], 1'b0};          sc_c = bus.in_a[N-1]; sc_v = 1'b0; end
         OP_SHR: begin sc_res = {1'b0, bus.in_a[N-1:1]};          sc_c = bus.in_a[0];   sc_v = 1'b0; end
         OP_ROL: begin sc_res = {bus.in_a[N-2:0], bus.in_a[N-1]}; sc_c = bus.in_a[N-1]; sc_v = 1'b0; end
         OP_ROR: begin sc_res = {bus.in_a[0], bus.in_a[N-1:1]};   sc_c = bus.in_a[0];   sc_v = 1'b0; end
         OP_CMP: sc_cmp = 1'b1;
         OP_ILL: sc_err = 1'b1;
         default: ;
      endcase
   end

   // One radix-2 step: conditionally add the multiplicand into the high half, then shift right.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      mul_next = {mul_sum, acc_q[N-1:1]};
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      out_hi_d = out_hi_q;
      err_d    = err_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      neg_d    = neg_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               if (bus.mode == OP_MUL) begin
                  mcand_d = bus.in_a;
                  acc_d   = {{N{1'b0}}, bus.in_b};
                  cnt_d   = '0;
                  state_d = S_BUSY;
               end else begin
                  state_d  = S_DONE;
                  out_hi_d = '0;
                  if (sc_err) begin
                     out_d = '0;
                     err_d = 1'b1;
                  end else begin
                     out_d   = sc_cmp ? '0 : sc_res;
                     err_d   = 1'b0;
                     zero_d  = (sc_res == '0);
                     carry_d = sc_c;
                     neg_d   = sc_res[N-1];
                     ovf_d   = sc_v;
                  end
               end
            end
         end
         S_BUSY: begin
            acc_d = mul_next;
            cnt_d = cnt_q + N'(1);
            if (cnt_q == LAST) begin
               state_d  = S_DONE;
               out_d    = mul_next[N-1:0];
               out_hi_d = mul_next[2*N-1:N];
               err_d    = 1'b0;
               zero_d   = (mul_next == '0);
               carry_d  = (mul_next[2*N-1:N] != '0);
               neg_d    = mul_next[2*N-1];
               ovf_d    = 1'b0;
            end
         end
         S_DONE: begin
            if (bus.out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         out_q    <= '0;
         out_hi_q <= '0;
         err_q    <= 1'b0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         out_hi_q <= out_hi_d;
         err_q    <= err_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         neg_q    <= neg_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.in_ready      = rst_n && (state_q == S_IDLE);
   assign bus.out_valid     = (state_q == S_DONE);
   assign bus.out           = out_q;
   assign bus.out_hi        = out_hi_q;
   assign bus.out_err       = err_q;
   assign bus.flag_zero     = zero_q;
   assign bus.flag_carry    = carry_q;
   assign bus.flag_negative = neg_q;
   assign bus.flag_overflow = ovf_q;

endmodule
